mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by an instruction-fetch port and a data port.
// Data accesses win by default; a 2-bit starvation counter forces a fetch grant after two back-to-back data grants.
module mem_port_arbiter #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ack,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ready,
    output logic          if_stall,
    output logic          mem_stall,
    output logic          timeout_err
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_e;

    state_e        state_q, state_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          mem_ack_q, mem_ack_d;
    logic [1:0]    starve_q, starve_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          terr_q, terr_d;

    // A port whose ack is on the output this cycle must not be re-granted on its held request.
    logic if_go, mem_go;
    assign if_go  = if_req & ~if_ack_q;
    assign mem_go = mem_req & ~mem_ack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            starve_q    <= '0;
            wait_q      <= '0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            terr_q      <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_go && !(starve_q == 2'd2 && if_go)) state_d = D_ACC;
                else if (if_go)                             state_d = I_ACC;
            end
            D_ACC, I_ACC: begin
                // The cycle that would be the TIMEOUT-th wait ends the access instead.
                if (bus_ready || wait_q == WW'(TIMEOUT - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic in_acc, finish, timed_out;

    always_comb begin
        bus_req_d   = (state_d != IDLE);
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        starve_d    = starve_q;
        wait_d      = wait_q;
        terr_d      = terr_q;
        in_acc      = (state_q != IDLE);
        finish      = in_acc && (state_d == IDLE);
        timed_out   = finish && !bus_ready;

        if (state_q == IDLE && state_d == D_ACC) begin
            bus_we_d    = mem_we;
            bus_addr_d  = mem_addr;
            bus_wdata_d = mem_wdata;
            wait_d      = '0;
            if (if_go) starve_d = (starve_q == 2'd2) ? 2'd2 : starve_q + 2'd1;
        end
        if (state_q == IDLE && state_d == I_ACC) begin
            bus_we_d    = 1'b0;
            bus_addr_d  = if_addr;
            bus_wdata_d = '0;
            wait_d      = '0;
            starve_d    = '0;
        end

        if (in_acc && !bus_ready) wait_d = wait_q + WW'(1);

        if (finish) begin
            if (state_q == I_ACC) begin
                if_ack_d   = 1'b1;
                if_rdata_d = timed_out ? '0 : bus_rdata;
            end else begin
                mem_ack_d = 1'b1;
                if (!bus_we_q) mem_rdata_d = timed_out ? '0 : bus_rdata;
            end
        end
        if (timed_out) terr_d = 1'b1;
    end

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign mem_rdata   = mem_rdata_q;
    assign if_ack      = if_ack_q;
    assign mem_ack     = mem_ack_q;
    assign timeout_err = terr_q;
    assign if_stall    = if_req & ~if_ack_q;
    assign mem_stall   = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random two-master traffic against a transaction-level model of the arbiter; every output checked each cycle.
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, mem_req, mem_we, bus_ready;
    logic [AW-1:0] if_addr, mem_addr;
    logic [DW-1:0] mem_wdata, bus_rdata;
    logic [DW-1:0] if_rdata, mem_rdata, bus_wdata;
    logic [AW-1:0] bus_addr;
    logic          if_ack, mem_ack, bus_req, bus_we, if_stall, mem_stall, timeout_err;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .if_stall(if_stall), .mem_stall(mem_stall), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: the access in flight as one record, plus the port-level results it produced.
    typedef struct {
        bit            act;
        bit            data;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
    } acc_t;

    acc_t          cur;
    int            starve;
    bit            m_if_ack, m_mem_ack, m_terr;
    logic [DW-1:0] m_if_rd, m_mem_rd;

    task automatic model_reset();
        cur       = '{0, 0, 0, '0, '0, 0};
        starve    = 0;
        m_if_ack  = 0;
        m_mem_ack = 0;
        m_terr    = 0;
        m_if_rd   = '0;
        m_mem_rd  = '0;
    endtask

    task automatic model_step();
        bit pi, pm, wi, wm, to;
        pi = 0;
        pm = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (cur.act) begin
            if (bus_ready || cur.waits + 1 == TO) begin
                to = !bus_ready;
                if (cur.data) begin
                    pm = 1;
                    if (!cur.we) m_mem_rd = to ? '0 : bus_rdata;
                end else begin
                    pi = 1;
                    m_if_rd = to ? '0 : bus_rdata;
                end
                if (to) m_terr = 1;
                cur.act = 0;
            end else begin
                cur.waits++;
            end
        end else begin
            wi = if_req && !m_if_ack;
            wm = mem_req && !m_mem_ack;
            if (wm && !(starve == 2 && wi)) begin
                cur = '{1, 1, mem_we, mem_addr, mem_wdata, 0};
                if (wi) starve = (starve < 2) ? starve + 1 : 2;
            end else if (wi) begin
                cur    = '{1, 0, 0, if_addr, '0, 0};
                starve = 0;
            end
        end
        m_if_ack  = pi;
        m_mem_ack = pm;
    endtask

    task automatic check_all();
        chk("bus_req", bus_req, cur.act);
        chk("bus_we", bus_we, cur.we);
        chk("bus_addr", bus_addr, cur.addr);
        chk("bus_wdata", bus_wdata, cur.wdata);
        chk("if_ack", if_ack, m_if_ack);
        chk("mem_ack", mem_ack, m_mem_ack);
        chk("if_rdata", if_rdata, m_if_rd);
        chk("mem_rdata", mem_rdata, m_mem_rd);
        chk("timeout_err", timeout_err, m_terr);
        chk("if_stall", if_stall, if_req && !m_if_ack);
        chk("mem_stall", mem_stall, mem_req && !m_mem_ack);
        chk("dual_ack", if_ack & mem_ack, 1'b0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = ($urandom_range(7) == 0) ? {AW{1'b1}} : AW'($urandom);
        return a;
    endfunction

    // Masters hold a request until its ack; memory answers with the given probability.
    task automatic drive(input int rdy_pct, input int rst_pct);
        rst = ($urandom_range(99) < rst_pct);
        if (!if_req || m_if_ack) begin
            if_req  = ($urandom_range(99) < 60);
            if_addr = rand_addr();
        end
        if (!mem_req || m_mem_ack) begin
            mem_req   = ($urandom_range(99) < 60);
            mem_we    = $urandom_range(1);
            mem_addr  = rand_addr();
            mem_wdata = $urandom;
        end
        bus_ready = ($urandom_range(99) < rdy_pct);
        bus_rdata = $urandom;
    endtask

    initial begin
        model_reset();
        rst = 1; if_req = 0; mem_req = 0; mem_we = 0; bus_ready = 0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; bus_rdata = '0;
        repeat (2) cycle();

        // Single fetch held through its ack, then re-granted.
        rst = 0; if_req = 1; if_addr = 10'h004; bus_ready = 1; bus_rdata = 32'h20080005;
        repeat (5) cycle();

        // Store with three wait cycles on the bus.
        if_req = 0;
        repeat (3) cycle();
        mem_req = 1; mem_we = 1; mem_addr = 10'h010; mem_wdata = 32'hCAFEF00D; bus_ready = 0;
        repeat (4) cycle();
        bus_ready = 1;
        cycle();
        mem_req = 0;
        repeat (2) cycle();

        // Both ports requesting continuously with an always-ready memory.
        if_req = 1; mem_req = 1; mem_we = 0;
        repeat (16) begin
            cycle();
            if (m_if_ack) if_addr = rand_addr();
            if (m_mem_ack) mem_addr = rand_addr();
            bus_rdata = $urandom;
        end

        // Memory never answers: every access times out.
        for (int i = 0; i < 60; i++) begin
            cycle();
            drive(0, 0);
        end
        for (int i = 0; i < 400; i++) begin
            cycle();
            drive(50, 0);
        end
        for (int i = 0; i < 600; i++) begin
            cycle();
            drive(40, 4);
        end
        for (int i = 0; i < 300; i++) begin
            cycle();
            drive(($urandom_range(3) == 0) ? 0 : 70, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
